mmio_uart_tx: RTL and testbench

- Memory-mapped UART transmitter on the RV32I multicycle core's data memory port (address, data_out, r_en_mem, w_en_mem, MemData).
- Decodes a 16-byte window. Stores push bytes into a small FIFO, and a serialiser shifts them out as 8N1 frames.
- Read data is combinational so the core can capture it into MDR in the same cycle. A level IRQ signals that the transmitter has drained.

---
 rtl/mmio_uart_pkg.sv | 28 ++
 rtl/uart_tx_fifo.sv | 64 ++++++
 rtl/mmio_uart_tx.sv | 196 +++++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_uart_pkg.sv
// mmio_uart_pkg: shared definitions for the memory-mapped UART transmitter.
//   - Register offsets, as decoded from address[3:2].
//   - STATUS and CTRL bit positions.
//   - Serialiser FSM state type.
package mmio_uart_pkg;

  localparam logic [1:0] OFF_TXDATA = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_BAUD   = 2'd2;
  localparam logic [1:0] OFF_CTRL   = 2'd3;

  localparam int ST_BUSY  = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_EMPTY = 2;
  localparam int ST_OVF   = 3;
  localparam int ST_COUNT = 8;

  localparam int CTRL_TX_EN  = 0;
  localparam int CTRL_IRQ_EN = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous FIFO with a first-word-fall-through head.
// Ports:
//   clk, rst_n    - clock, asynchronous active-low reset
//   push, wdata   - write request and data (accepted when not full, or when
//                   a pop happens in the same cycle)
//   pop           - removes the head entry (ignored when empty)
//   rdata         - current head entry
//   full, empty   - occupancy flags
//   count         - number of stored entries, 0..DEPTH
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot the push lands in.
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop) begin
        count <= count + CW'(1);
      end else if (do_pop && !do_push) begin
        count <= count - CW'(1);
      end
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter for the core's data port.
// Ports:
//   clk_in, rst_in      - clock, asynchronous active-low reset
//   address, wdata      - core byte address and store data
//   r_en_mem, w_en_mem  - core read / write strobes
//   hit                 - address falls inside the 16-byte register window
//   rdata               - combinational register read data (0 when not read)
//   tx                  - serial line, idle high
//   irq                 - registered level interrupt: drained and idle
module mmio_uart_tx
  import mmio_uart_pkg::*;
#(
  parameter logic [31:0]      BASE_ADDR  = 32'h1000_0000,
  parameter int               FIFO_DEPTH = 4,
  parameter int               DIV_W      = 16,
  parameter logic [DIV_W-1:0] DIV_RESET  = 16'd434
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] address,
  input  logic [31:0] wdata,
  input  logic        r_en_mem,
  input  logic        w_en_mem,
  output logic        hit,
  output logic [31:0] rdata,
  output logic        tx,
  output logic        irq
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]       offset;
  logic             wr_hit;
  logic             push;
  logic             pop;
  logic             busy;
  logic             bit_done;
  logic [DIV_W-1:0] div_reg;
  logic [DIV_W-1:0] div_active;
  logic [DIV_W-1:0] baud_cnt;
  logic             tx_en;
  logic             irq_en;
  logic             overflow;
  tx_state_t        state;
  logic [7:0]       shift_reg;
  logic [2:0]       bit_cnt;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CW-1:0]    fifo_count;
  logic [7:0]       fifo_head;
  logic [31:0]      status_word;
  logic             unused_bits;

  assign hit         = (address[31:4] == BASE_ADDR[31:4]);
  assign offset      = address[3:2];
  assign wr_hit      = hit & w_en_mem;
  assign push        = wr_hit & (offset == OFF_TXDATA);
  assign busy        = (state != IDLE);
  assign pop         = (state == IDLE) & tx_en & ~fifo_empty;
  // Last cycle of the current bit period (start, data or stop).
  assign bit_done    = (baud_cnt == div_active - DIV_W'(1));
  assign unused_bits = &{1'b0, address[1:0], wdata[31:DIV_W]};

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk_in),
    .rst_n (rst_in),
    .push  (push),
    .wdata (wdata[7:0]),
    .pop   (pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Control / configuration registers.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      div_reg  <= DIV_RESET;
      tx_en    <= 1'b1;
      irq_en   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (push && fifo_full && !pop) begin
        overflow <= 1'b1;
      end
      if (wr_hit) begin
        case (offset)
          OFF_STATUS: if (wdata[ST_OVF]) overflow <= 1'b0;
          // A zero divider would never finish a bit; store 1 instead.
          OFF_BAUD:   div_reg <= (wdata[DIV_W-1:0] == '0) ? DIV_W'(1) : wdata[DIV_W-1:0];
          OFF_CTRL: begin
            tx_en  <= wdata[CTRL_TX_EN];
            irq_en <= wdata[CTRL_IRQ_EN];
          end
          default: ;
        endcase
      end
    end
  end

  // Serialiser. tx is registered and set on the edge that enters each
  // phase, so the line changes exactly at bit boundaries.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state      <= IDLE;
      shift_reg  <= '0;
      div_active <= DIV_RESET;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      tx         <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          tx       <= 1'b1;
          baud_cnt <= '0;
          bit_cnt  <= '0;
          if (pop) begin
            shift_reg  <= fifo_head;
            div_active <= div_reg;  // later BAUDDIV writes wait for the next frame
            state      <= START;
            tx         <= 1'b0;
          end
        end
        START: begin
          if (bit_done) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            state    <= DATA;
            tx       <= shift_reg[0];
          end else begin
            baud_cnt <= baud_cnt + DIV_W'(1);
          end
        end
        DATA: begin
          if (bit_done) begin
            baud_cnt <= '0;
            if (bit_cnt == 3'd7) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              shift_reg <= {1'b0, shift_reg[7:1]};
              tx        <= shift_reg[1];
              bit_cnt   <= bit_cnt + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt + DIV_W'(1);
          end
        end
        STOP: begin
          if (bit_done) begin
            baud_cnt <= '0;
            state    <= IDLE;
            tx       <= 1'b1;
          end else begin
            baud_cnt <= baud_cnt + DIV_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      irq <= 1'b0;
    end else begin
      irq <= irq_en & fifo_empty & ~busy;
    end
  end

  always_comb begin
    status_word                  = '0;
    status_word[ST_BUSY]         = busy;
    status_word[ST_FULL]         = fifo_full;
    status_word[ST_EMPTY]        = fifo_empty;
    status_word[ST_OVF]          = overflow;
    status_word[ST_COUNT +: CW]  = fifo_count;
    rdata = '0;
    if (hit && r_en_mem) begin
      case (offset)
        OFF_STATUS: rdata = status_word;
        OFF_BAUD:   rdata[DIV_W-1:0] = div_reg;
        OFF_CTRL: begin
          rdata[CTRL_TX_EN]  = tx_en;
          rdata[CTRL_IRQ_EN] = irq_en;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
`timescale 1ns/1ps
module tb_mmio_uart_tx;

  localparam logic [31:0] A_TX = 32'h1000_0000;
  localparam logic [31:0] A_ST = 32'h1000_0004;
  localparam logic [31:0] A_BD = 32'h1000_0008;
  localparam logic [31:0] A_CT = 32'h1000_000C;

  logic        clk_in;
  logic        rst_in;
  logic [31:0] address;
  logic [31:0] wdata;
  logic        r_en_mem;
  logic        w_en_mem;
  logic        hit;
  logic [31:0] rdata;
  logic        tx;
  logic        irq;

  mmio_uart_tx dut (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .address  (address),
    .wdata    (wdata),
    .r_en_mem (r_en_mem),
    .w_en_mem (w_en_mem),
    .hit      (hit),
    .rdata    (rdata),
    .tx       (tx),
    .irq      (irq)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Reference model: every accepted byte becomes one expected frame.
  // A frame carries the divider in force when its byte leaves the FIFO;
  // the stimulus never rewrites BAUDDIV while a byte is still queued, so
  // the value at push time is the same.
  typedef struct {
    logic [7:0] data;
    int         div;
  } frame_t;

  frame_t exp_q[$];
  int     model_div;
  int     n_checks;
  int     n_pass;
  bit     mon_active;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, required %h", name, act, exp);
  endtask

  // All bus tasks start just after a falling edge and return on the next one.
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    address  = a;
    wdata    = d;
    w_en_mem = 1'b1;
    @(negedge clk_in);
    w_en_mem = 1'b0;
  endtask

  task automatic rd_check(input string name, input logic [31:0] a, input logic [31:0] exp);
    address  = a;
    r_en_mem = 1'b1;
    #1;
    check(name, rdata, exp);
    @(negedge clk_in);
    r_en_mem = 1'b0;
  endtask

  task automatic set_div(input int d);
    wr(A_BD, 32'(d));
    model_div = (d == 0) ? 1 : d;
  endtask

  task automatic send(input logic [7:0] b);
    logic [31:0] d;
    d      = $urandom;
    d[7:0] = b;
    exp_q.push_back('{b, model_div});
    wr(A_TX, d);
  endtask

  task automatic wait_drain(input string name);
    int w;
    w = 0;
    while ((exp_q.size() != 0 || mon_active) && w < 20000) begin
      @(negedge clk_in);
      w++;
    end
    check(name, 32'(exp_q.size()) + 32'(mon_active), 32'h0);
    repeat (2) @(negedge clk_in);
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_tx"}, 32'(tx), 32'h1);
    check({tag, "_irq"}, 32'(irq), 32'h0);
    rd_check({tag, "_status"}, A_ST, 32'h0000_0004);
    rd_check({tag, "_baud"}, A_BD, 32'd434);
    rd_check({tag, "_ctrl"}, A_CT, 32'h1);
  endtask

  // Line level for slot 0 (start), 1..8 (data LSB first), 9 (stop).
  function automatic logic line_level(input logic [7:0] d, input int slot);
    if (slot == 0) return 1'b0;
    if (slot <= 8) return d[slot-1];
    return 1'b1;
  endfunction

  // Monitor: on each start bit, pop the expected frame and compare the
  // line every cycle for 10*div cycles plus the trailing idle-high cycle.
  initial begin : monitor
    frame_t f;
    int     bad_at;
    logic   bad_val;
    logic   exp_lvl;
    bit     aborted;
    mon_active = 1'b0;
    forever begin
      @(negedge clk_in);
      if (rst_in === 1'b1 && tx === 1'b0) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_frame: tx=0 at %0t, required idle 1", $time);
          for (int w = 0; w < 4000 && tx !== 1'b1; w++) @(negedge clk_in);
        end else begin
          f          = exp_q.pop_front();
          mon_active = 1'b1;
          bad_at     = -1;
          bad_val    = 1'b0;
          aborted    = 1'b0;
          for (int k = 0; k < 10 * f.div + 1; k++) begin
            if (k > 0) @(negedge clk_in);
            if (rst_in !== 1'b1) begin
              aborted = 1'b1;
              break;
            end
            exp_lvl = (k == 10 * f.div) ? 1'b1 : line_level(f.data, k / f.div);
            if (tx !== exp_lvl && bad_at < 0) begin
              bad_at  = k;
              bad_val = tx;
            end
          end
          if (aborted) begin
            $display("frame data=%02h div=%0d cut by reset", f.data, f.div);
          end else begin
            n_checks++;
            if (bad_at < 0) begin
              n_pass++;
              $display("frame data=%02h div=%0d ok", f.data, f.div);
            end else begin
              $display("FAIL frame data=%02h div=%0d: tx=%b at cycle %0d, required %b",
                       f.data, f.div, bad_val, bad_at,
                       (bad_at == 10 * f.div) ? 1'b1 : line_level(f.data, bad_at / f.div));
            end
          end
          mon_active = 1'b0;
        end
      end
    end
  end

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int busy_cycles;
    bit irq_early;
    logic [7:0] b;
    rst_in    = 1'b0;
    address   = '0;
    wdata     = '0;
    r_en_mem  = 1'b0;
    w_en_mem  = 1'b0;
    model_div = 434;
    n_checks  = 0;
    n_pass    = 0;
    repeat (3) @(negedge clk_in);
    rst_in = 1'b1;
    reset_checks("init");

    // Decode: outside the window nothing is hit, read or pushed.
    wr(32'h1000_0010, 32'h77);
    address = 32'h0FFF_FFFC; r_en_mem = 1'b1; #1;
    check("miss_hit", 32'(hit), 32'h0);
    check("miss_rdata", rdata, 32'h0);
    address = A_ST | 32'h3; #1;
    check("lowbits_hit", 32'(hit), 32'h1);
    @(negedge clk_in); r_en_mem = 1'b0;
    rd_check("miss_no_push", A_ST, 32'h0000_0004);

    // Zero divider is stored as 1.
    set_div(0);
    rd_check("baud_zero", A_BD, 32'h1);

    // Single byte with latency and busy length.
    set_div(4);
    send(8'h55);
    check("lat_before_pop", 32'(tx), 32'h1);
    address = A_ST; r_en_mem = 1'b1; busy_cycles = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_in);
      if (i == 0) check("lat_start_low", 32'(tx), 32'h0);
      if (rdata[0]) busy_cycles++;
      else if (busy_cycles > 0) break;
    end
    r_en_mem = 1'b0;
    check("busy_cycles", 32'(busy_cycles), 32'd40);
    wait_drain("drain_single");

    // Overflow: first byte pops, four fill, the sixth is dropped.
    set_div(100);
    for (int i = 1; i <= 6; i++) begin
      if (i <= 5) exp_q.push_back('{8'(i), 100});
      wr(A_TX, 32'(i));
    end
    rd_check("ovf_status", A_ST, 32'h0000_040B);
    wr(A_ST, 32'h8);
    rd_check("ovf_cleared", A_ST, 32'h0000_0403);
    wait_drain("drain_overflow");
    rd_check("ovf_after_drain", A_ST, 32'h0000_0004);

    // Baud change mid-frame affects only the queued frame.
    set_div(4);
    send(8'hA0);
    repeat (10) @(negedge clk_in);
    set_div(8);
    send(8'h0F);
    rd_check("baud_mid", A_BD, 32'd8);
    wait_drain("drain_baud");

    // Disabled transmitter holds the byte; enabling sends it, then irq.
    set_div(3);
    wr(A_CT, 32'h2);
    send(8'h33);
    repeat (50) @(negedge clk_in);
    check("dis_irq", 32'(irq), 32'h0);
    check("dis_tx", 32'(tx), 32'h1);
    rd_check("dis_status", A_ST, 32'h0000_0100);
    rd_check("dis_ctrl", A_CT, 32'h2);
    wr(A_CT, 32'h3);
    irq_early = 1'b0;
    for (int i = 1; i <= 31; i++) begin
      @(negedge clk_in);
      if (irq) irq_early = 1'b1;
    end
    check("irq_not_early", 32'(irq_early), 32'h0);
    @(negedge clk_in);
    check("irq_after_stop", 32'(irq), 32'h1);
    wait_drain("drain_irq");

    // Randomised bursts with random dividers and spacing.
    for (int r = 0; r < 6; r++) begin
      set_div(int'($urandom_range(1, 6)));
      for (int j = 0; j < int'($urandom_range(1, 3)); j++) begin
        b = 8'($urandom);
        send(b);
        repeat ($urandom_range(0, 3)) @(negedge clk_in);
      end
      wait_drain("drain_random");
    end
    check("irq_idle", 32'(irq), 32'h1);

    // Reset mid-frame discards everything.
    wr(A_CT, 32'h1);
    set_div(10);
    for (int j = 0; j < 3; j++) send(8'($urandom));
    repeat (25) @(negedge clk_in);
    #2 rst_in = 1'b0;
    exp_q.delete();
    #1 check("rst_tx_immediate", 32'(tx), 32'h1);
    repeat (2) @(negedge clk_in);
    rst_in = 1'b1;
    reset_checks("mid");
    model_div = 434;
    repeat (300) @(negedge clk_in);
    check("post_rst_tx", 32'(tx), 32'h1);
    rd_check("post_rst_status", A_ST, 32'h0000_0004);

    check("final_queue", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
